// File: rtl/usb_wire_rx_packetizer.sv
`timescale 1ns/1ps
// USB wire receiver: SYNC detect, NRZI decode, bit unstuffing and EOP handling,
// packing LSB-first bytes into a small FWFT FIFO tagged with last/error flags.
module usb_wire_rx_packetizer #(
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       usb_full_speed_i,
  input  logic [1:0] usb_wire_data_i,
  input  logic       usb_wire_tick_i,
  input  logic       usb_wire_ctrl_i,
  output logic [7:0] pkt_data_o,
  output logic       pkt_last_o,
  output logic       pkt_err_o,
  output logic       pkt_valid_o,
  input  logic       pkt_ready_i,
  output logic       drop_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    EOP  = 2'd3
  } state_t;

  localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ZERO = {(FIFO_ADDR_WIDTH+1){1'b0}};
  localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ONE  = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [FIFO_ADDR_WIDTH:0]   CNT_FULL = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = {{(FIFO_ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t      state_r, state_n;
  logic [1:0]  prev_r, prev_n;
  logic [3:0]  zero_r, zero_n;
  logic [2:0]  ones_r, ones_n;
  logic [2:0]  bit_cnt_r, bit_cnt_n;
  logic [7:0]  shift_r, shift_n;
  logic [7:0]  stage_r, stage_n;
  logic        stage_vld_r, stage_vld_n;
  logic        perr_r, perr_n;
  logic [2:0]  se0_cnt_r, se0_cnt_n;
  logic        push_r, push_n;
  logic [7:0]  push_data_r, push_data_n;
  logic        push_last_r, push_last_n;
  logic        push_err_r, push_err_n;
  logic        close_s, close_err_s;

  logic [1:0]  j_s, k_s;
  logic        samp_s, bit_s, is_j_s, is_k_s, is_se0_s, is_se1_s;

  logic [9:0]                 mem_r [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_ADDR_WIDTH:0]   count_r;
  logic                       full_s, pop_s, wr_en_s;
  logic [9:0]                 head_s;

  assign j_s      = usb_full_speed_i ? 2'b10 : 2'b01;
  assign k_s      = ~j_s;
  assign samp_s   = usb_wire_tick_i & usb_wire_ctrl_i;
  assign is_j_s   = (usb_wire_data_i == j_s);
  assign is_k_s   = (usb_wire_data_i == k_s);
  assign is_se0_s = (usb_wire_data_i == 2'b00);
  assign is_se1_s = (usb_wire_data_i == 2'b11);
  assign bit_s    = (usb_wire_data_i == prev_r);

  // Receive FSM and datapath next-state logic
  always_comb begin
    state_n     = state_r;
    zero_n      = zero_r;
    ones_n      = ones_r;
    bit_cnt_n   = bit_cnt_r;
    shift_n     = shift_r;
    stage_n     = stage_r;
    stage_vld_n = stage_vld_r;
    perr_n      = perr_r;
    se0_cnt_n   = se0_cnt_r;
    push_n      = 1'b0;
    push_data_n = push_data_r;
    push_last_n = push_last_r;
    push_err_n  = push_err_r;
    close_s     = 1'b0;
    close_err_s = 1'b0;

    if (samp_s) begin
      prev_n = usb_wire_data_i;
    end else begin
      prev_n = prev_r;
    end

    case (state_r)
      IDLE: begin
        if (samp_s && is_k_s && (prev_r == j_s)) begin
          state_n = SYNC;
          zero_n  = 4'd1;
          perr_n  = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      SYNC: begin
        if (!usb_wire_ctrl_i) begin
          close_s     = 1'b1;
          close_err_s = 1'b1;
        end else if (samp_s) begin
          if (is_se0_s || is_se1_s) begin
            state_n = IDLE;
          end else if (!bit_s) begin
            zero_n = (zero_r == 4'd15) ? zero_r : zero_r + 4'd1;
          end else if (zero_r == 4'd7) begin
            state_n     = DATA;
            ones_n      = 3'd0;
            bit_cnt_n   = 3'd0;
            shift_n     = 8'h00;
            stage_vld_n = 1'b0;
            perr_n      = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = SYNC;
        end
      end
      DATA: begin
        if (!usb_wire_ctrl_i) begin
          close_s     = 1'b1;
          close_err_s = 1'b1;
        end else if (samp_s) begin
          if (is_se0_s) begin
            state_n   = EOP;
            se0_cnt_n = 3'd1;
          end else if (is_se1_s) begin
            perr_n = 1'b1;
          end else if (ones_r == 3'd6) begin
            // Stuff position: the bit is dropped, and a 1 here is a stuffing violation
            ones_n = 3'd0;
            perr_n = perr_r | bit_s;
          end else begin
            ones_n    = bit_s ? ones_r + 3'd1 : 3'd0;
            shift_n   = {bit_s, shift_r[7:1]};
            bit_cnt_n = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              stage_n     = {bit_s, shift_r[7:1]};
              stage_vld_n = 1'b1;
              push_n      = stage_vld_r;
              push_data_n = stage_r;
              push_last_n = 1'b0;
              push_err_n  = 1'b0;
            end else begin
              stage_n = stage_r;
            end
          end
        end else begin
          state_n = DATA;
        end
      end
      EOP: begin
        if (!usb_wire_ctrl_i) begin
          close_s     = 1'b1;
          close_err_s = 1'b1;
        end else if (samp_s) begin
          if (is_se0_s) begin
            if (se0_cnt_r == 3'd3) begin
              close_s     = 1'b1;
              close_err_s = 1'b1;
            end else begin
              se0_cnt_n = se0_cnt_r + 3'd1;
            end
          end else if (is_j_s) begin
            close_s     = 1'b1;
            close_err_s = perr_r | (bit_cnt_r != 3'd0);
          end else if (is_k_s) begin
            close_s     = 1'b1;
            close_err_s = 1'b1;
          end else begin
            perr_n = 1'b1;
          end
        end else begin
          state_n = EOP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Packet end (normal or aborted) flushes the staged byte as the last one
    if (close_s) begin
      state_n     = IDLE;
      stage_vld_n = 1'b0;
      push_n      = stage_vld_r;
      push_data_n = stage_r;
      push_last_n = 1'b1;
      push_err_n  = close_err_s;
    end else begin
      close_err_s = close_err_s;
    end
  end

  // Receive state registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r     <= IDLE;
      prev_r      <= j_s;
      zero_r      <= 4'd0;
      ones_r      <= 3'd0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      stage_r     <= 8'h00;
      stage_vld_r <= 1'b0;
      perr_r      <= 1'b0;
      se0_cnt_r   <= 3'd0;
      push_r      <= 1'b0;
      push_data_r <= 8'h00;
      push_last_r <= 1'b0;
      push_err_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      prev_r      <= prev_n;
      zero_r      <= zero_n;
      ones_r      <= ones_n;
      bit_cnt_r   <= bit_cnt_n;
      shift_r     <= shift_n;
      stage_r     <= stage_n;
      stage_vld_r <= stage_vld_n;
      perr_r      <= perr_n;
      se0_cnt_r   <= se0_cnt_n;
      push_r      <= push_n;
      push_data_r <= push_data_n;
      push_last_r <= push_last_n;
      push_err_r  <= push_err_n;
    end
  end

  // A full FIFO still takes a push when the head is popped in the same cycle
  assign full_s  = (count_r == CNT_FULL);
  assign pop_s   = (count_r != CNT_ZERO) & pkt_ready_i;
  assign wr_en_s = push_r & (~full_s | pop_s);
  assign drop_o  = push_r & full_s & ~pop_s;

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {push_err_r, push_last_r, push_data_r};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_r <= {FIFO_ADDR_WIDTH{1'b0}};
      rd_ptr_r <= {FIFO_ADDR_WIDTH{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_s      = mem_r[rd_ptr_r];
  assign pkt_valid_o = (count_r != CNT_ZERO);
  assign pkt_data_o  = pkt_valid_o ? head_s[7:0] : 8'h00;
  assign pkt_last_o  = pkt_valid_o & head_s[8];
  assign pkt_err_o   = pkt_valid_o & head_s[9];

endmodule
